// File: rtl/frame_snapshot_pkg.sv
// Shared sizes, reset constants and FSM state type for the frame snapshot receiver.
package frame_snapshot_pkg;

    localparam int N_OBS_DEF    = 10;
    localparam int X_W_DEF      = 10;
    localparam int Y_W_DEF      = 9;

    localparam int OBS_X_RST    = 700;
    localparam int OBS_Y_RST    = 500;
    localparam int PLAYER_Y_RST = 240;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VB,
        DONE
    } state_t;

endpackage

// File: rtl/frame_snapshot_rx_tgl_sync.sv
// Multi-flop synchroniser that carries the game-domain request toggle into the pixel clock domain.
module tgl_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tgl,
    output logic o_tgl
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_tgl};
        end
    end

    assign o_tgl = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/frame_snapshot_rx.sv
// Captures staged game state into renderer shadows only at the start of vertical sync.
// Define FRAME_SNAPSHOT_STATS_EN to add the frame_cnt / stale_cnt statistics outputs.
module frame_snapshot_rx
    import frame_snapshot_pkg::*;
#(
    parameter int N_OBS       = N_OBS_DEF,
    parameter int X_W         = X_W_DEF,
    parameter int Y_W         = Y_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_tgl,
    input  logic                 vs,
    input  logic [N_OBS*X_W-1:0] obs_x_left_in,
    input  logic [N_OBS*X_W-1:0] obs_x_right_in,
    input  logic [N_OBS*Y_W-1:0] obs_y_up_in,
    input  logic [N_OBS*Y_W-1:0] obs_y_down_in,
    input  logic [Y_W-1:0]       player_y_in,
    input  logic [1:0]           gamemode_in,
    output logic                 ack_tgl,
    output logic [N_OBS*X_W-1:0] obs_x_left,
    output logic [N_OBS*X_W-1:0] obs_x_right,
    output logic [N_OBS*Y_W-1:0] obs_y_up,
    output logic [N_OBS*Y_W-1:0] obs_y_down,
    output logic [Y_W-1:0]       player_y,
    output logic [1:0]           gamemode,
    output logic                 snap_upd
`ifdef FRAME_SNAPSHOT_STATS_EN
    ,
    output logic [15:0]          frame_cnt,
    output logic [15:0]          stale_cnt
`endif
);

    localparam logic [X_W-1:0] X_RST  = X_W'(OBS_X_RST);
    localparam logic [Y_W-1:0] Y_RST  = Y_W'(OBS_Y_RST);
    localparam logic [Y_W-1:0] PY_RST = Y_W'(PLAYER_Y_RST);

    state_t               r_state;
    state_t               w_next;
    logic                 r_vs_d;
    logic                 r_ack;
    logic                 w_req_s;
    logic                 w_req_pend;
    logic                 w_vs_edge;
    logic                 w_capture;
    logic [N_OBS*X_W-1:0] r_obs_x_left;
    logic [N_OBS*X_W-1:0] r_obs_x_right;
    logic [N_OBS*Y_W-1:0] r_obs_y_up;
    logic [N_OBS*Y_W-1:0] r_obs_y_down;
    logic [Y_W-1:0]       r_player_y;
    logic [1:0]           r_gamemode;

    tgl_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tgl_sync (
        .clk   (clk),
        .rst   (rst),
        .i_tgl (req_tgl),
        .o_tgl (w_req_s)
    );

    assign w_req_pend = w_req_s ^ r_ack;
    assign w_vs_edge  = r_vs_d & ~vs;

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_pend) begin
                    if (w_vs_edge) begin
                        w_next    = DONE;
                        w_capture = 1'b1;
                    end else begin
                        w_next = WAIT_VB;
                    end
                end
            end
            WAIT_VB: begin
                if (w_vs_edge) begin
                    w_next    = DONE;
                    w_capture = 1'b1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The ack flips as DONE is left, one cycle after the shadows became visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_vs_d  <= 1'b1;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_vs_d  <= vs;
            if (r_state == DONE) begin
                r_ack <= ~r_ack;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_obs_x_left  <= {N_OBS{X_RST}};
            r_obs_x_right <= {N_OBS{X_RST}};
            r_obs_y_up    <= {N_OBS{Y_RST}};
            r_obs_y_down  <= {N_OBS{Y_RST}};
            r_player_y    <= PY_RST;
            r_gamemode    <= 2'd0;
        end else if (w_capture) begin
            r_obs_x_left  <= obs_x_left_in;
            r_obs_x_right <= obs_x_right_in;
            r_obs_y_up    <= obs_y_up_in;
            r_obs_y_down  <= obs_y_down_in;
            r_player_y    <= player_y_in;
            r_gamemode    <= gamemode_in;
        end
    end

    assign ack_tgl     = r_ack;
    assign obs_x_left  = r_obs_x_left;
    assign obs_x_right = r_obs_x_right;
    assign obs_y_up    = r_obs_y_up;
    assign obs_y_down  = r_obs_y_down;
    assign player_y    = r_player_y;
    assign gamemode    = r_gamemode;
    assign snap_upd    = (r_state == DONE);

`ifdef FRAME_SNAPSHOT_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_stale_cnt;

    // Frame count wraps; the stale count saturates so long idle periods stay readable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= 16'd0;
            r_stale_cnt <= 16'd0;
        end else if (w_vs_edge) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            if (!w_capture && (r_stale_cnt != 16'hFFFF)) begin
                r_stale_cnt <= r_stale_cnt + 16'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign stale_cnt = r_stale_cnt;
`endif

endmodule

// File: tb/tb_frame_snapshot_rx.sv
// Directed and randomized bench for frame_snapshot_rx, checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_frame_snapshot_rx;

    localparam int N_OBS       = 10;
    localparam int X_W         = 10;
    localparam int Y_W         = 9;
    localparam int SYNC_STAGES = 2;
    localparam int OX          = N_OBS * X_W;
    localparam int OY          = N_OBS * Y_W;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          req_tgl = 1'b0;
    logic          vs      = 1'b1;
    logic [OX-1:0] obs_x_left_in  = '0;
    logic [OX-1:0] obs_x_right_in = '0;
    logic [OY-1:0] obs_y_up_in    = '0;
    logic [OY-1:0] obs_y_down_in  = '0;
    logic [Y_W-1:0] player_y_in   = '0;
    logic [1:0]    gamemode_in    = '0;

    logic          ack_tgl;
    logic [OX-1:0] obs_x_left;
    logic [OX-1:0] obs_x_right;
    logic [OY-1:0] obs_y_up;
    logic [OY-1:0] obs_y_down;
    logic [Y_W-1:0] player_y;
    logic [1:0]    gamemode;
    logic          snap_upd;
`ifdef FRAME_SNAPSHOT_STATS_EN
    logic [15:0]   frame_cnt;
    logic [15:0]   stale_cnt;
`endif

    int checkCount = 0;
    int failCount  = 0;

    // Reference model state: what the renderer should see, derived from the handshake rules.
    logic [OX-1:0]  expXL, expXR;
    logic [OY-1:0]  expYU, expYD;
    logic [Y_W-1:0] expPY;
    logic [1:0]     expGM;
    logic           expAck  = 1'b0;
    logic           expSnap = 1'b0;
    logic           justCap = 1'b0;
    logic           vsPrev  = 1'b1;
    logic           reqHist [SYNC_STAGES];
    int             expFrames = 0;
    int             expStale  = 0;

    frame_snapshot_rx #(
        .N_OBS(N_OBS), .X_W(X_W), .Y_W(Y_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_tgl        (req_tgl),
        .vs             (vs),
        .obs_x_left_in  (obs_x_left_in),
        .obs_x_right_in (obs_x_right_in),
        .obs_y_up_in    (obs_y_up_in),
        .obs_y_down_in  (obs_y_down_in),
        .player_y_in    (player_y_in),
        .gamemode_in    (gamemode_in),
        .ack_tgl        (ack_tgl),
        .obs_x_left     (obs_x_left),
        .obs_x_right    (obs_x_right),
        .obs_y_up       (obs_y_up),
        .obs_y_down     (obs_y_down),
        .player_y       (player_y),
        .gamemode       (gamemode),
        .snap_upd       (snap_upd)
`ifdef FRAME_SNAPSHOT_STATS_EN
        ,
        .frame_cnt      (frame_cnt),
        .stale_cnt      (stale_cnt)
`endif
    );

    always #20 clk = ~clk;

    // A request is seen SYNC_STAGES edges after it is driven; it is captured at the first
    // falling vs it meets, except in the cycle straight after a capture. The ack follows one edge later.
    always @(posedge clk) begin
        logic reqSeen;
        logic vsFall;
        logic capNow;
        if (rst) begin
            for (int i = 0; i < N_OBS; i++) begin
                expXL[i*X_W +: X_W] = X_W'(700);
                expXR[i*X_W +: X_W] = X_W'(700);
                expYU[i*Y_W +: Y_W] = Y_W'(500);
                expYD[i*Y_W +: Y_W] = Y_W'(500);
            end
            expPY     = Y_W'(240);
            expGM     = 2'd0;
            expAck    = 1'b0;
            expSnap   = 1'b0;
            justCap   = 1'b0;
            vsPrev    = 1'b1;
            expFrames = 0;
            expStale  = 0;
            for (int k = 0; k < SYNC_STAGES; k++) reqHist[k] = 1'b0;
        end else begin
            reqSeen = reqHist[SYNC_STAGES-1];
            vsFall  = vsPrev && !vs;
            capNow  = vsFall && (reqSeen != expAck) && !justCap;
            if (justCap) expAck = !expAck;
            if (capNow) begin
                expXL = obs_x_left_in;
                expXR = obs_x_right_in;
                expYU = obs_y_up_in;
                expYD = obs_y_down_in;
                expPY = player_y_in;
                expGM = gamemode_in;
            end
            if (vsFall) begin
                expFrames = (expFrames + 1) % 65536;
                if (!capNow && expStale < 65535) expStale = expStale + 1;
            end
            expSnap = capNow;
            justCap = capNow;
            for (int k = SYNC_STAGES - 1; k > 0; k--) reqHist[k] = reqHist[k-1];
            reqHist[0] = req_tgl;
            vsPrev     = vs;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic compareModel();
        checkOutput("m_obs_x_left",  128'(obs_x_left),  128'(expXL));
        checkOutput("m_obs_x_right", 128'(obs_x_right), 128'(expXR));
        checkOutput("m_obs_y_up",    128'(obs_y_up),    128'(expYU));
        checkOutput("m_obs_y_down",  128'(obs_y_down),  128'(expYD));
        checkOutput("m_player_y",    128'(player_y),    128'(expPY));
        checkOutput("m_gamemode",    128'(gamemode),    128'(expGM));
        checkOutput("m_ack_tgl",     128'(ack_tgl),     128'(expAck));
        checkOutput("m_snap_upd",    128'(snap_upd),    128'(expSnap));
    endtask

    // Drive vs and the request toggle, then run the given number of cycles checking the model each cycle.
    task automatic applyStimulus(input logic vsVal, input logic reqVal, input int cycles);
        vs      = vsVal;
        req_tgl = reqVal;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            compareModel();
        end
    endtask

    task automatic randomizeData();
        for (int i = 0; i < N_OBS; i++) begin
            obs_x_left_in[i*X_W +: X_W]  = X_W'($urandom);
            obs_x_right_in[i*X_W +: X_W] = X_W'($urandom);
            obs_y_up_in[i*Y_W +: Y_W]    = Y_W'($urandom);
            obs_y_down_in[i*Y_W +: Y_W]  = Y_W'($urandom);
        end
        player_y_in = Y_W'($urandom);
        gamemode_in = 2'($urandom);
    endtask

    task automatic oneFrame(input logic reqVal);
        applyStimulus(1'b0, reqVal, 3);
        applyStimulus(1'b1, reqVal, 15);
    endtask

    initial begin
        // Reset defaults.
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("rst_obs_x_left0", 128'(obs_x_left[0 +: X_W]), 128'(700));
        checkOutput("rst_obs_y_up9",   128'(obs_y_up[9*Y_W +: Y_W]), 128'(500));
        checkOutput("rst_player_y",    128'(player_y), 128'(240));
        checkOutput("rst_gamemode",    128'(gamemode), 128'(0));
        checkOutput("rst_ack_tgl",     128'(ack_tgl), 128'(0));
        checkOutput("rst_snap_upd",    128'(snap_upd), 128'(0));
        rst = 1'b0;

        // Basic handshake with the request raised mid-frame.
        player_y_in = Y_W'(100);
        gamemode_in = 2'd1;
        applyStimulus(1'b1, 1'b0, 5);
        applyStimulus(1'b1, 1'b1, 8);
        checkOutput("hs_hold_player_y", 128'(player_y), 128'(240));
        checkOutput("hs_hold_snap_upd", 128'(snap_upd), 128'(0));
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("hs_player_y",  128'(player_y), 128'(100));
        checkOutput("hs_gamemode",  128'(gamemode), 128'(1));
        checkOutput("hs_snap_upd",  128'(snap_upd), 128'(1));
        checkOutput("hs_ack_early", 128'(ack_tgl), 128'(0));
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("hs_ack_tgl",   128'(ack_tgl), 128'(1));
        checkOutput("hs_snap_once", 128'(snap_upd), 128'(0));
        applyStimulus(1'b0, 1'b1, 2);
        applyStimulus(1'b1, 1'b1, 10);

        // Tear-freedom: unrequested input changes never reach the shadows.
        obs_x_left_in[3*X_W +: X_W] = X_W'(200);
        applyStimulus(1'b1, 1'b0, 4);
        oneFrame(1'b0);
        checkOutput("tear_capture_200", 128'(obs_x_left[3*X_W +: X_W]), 128'(200));
        obs_x_left_in[3*X_W +: X_W] = X_W'(300);
        for (int f = 0; f < 3; f++) begin
            oneFrame(1'b0);
            checkOutput("tear_hold_200", 128'(obs_x_left[3*X_W +: X_W]), 128'(200));
        end

        // Synchronised request arrives in the same cycle as the vs falling edge.
        player_y_in = Y_W'(77);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, SYNC_STAGES - 1);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("simul_player_y", 128'(player_y), 128'(77));
        checkOutput("simul_snap_upd", 128'(snap_upd), 128'(1));
        applyStimulus(1'b0, 1'b1, 2);
        applyStimulus(1'b1, 1'b1, 10);

        // Reset while waiting for vertical sync discards the pending capture.
        player_y_in = Y_W'(55);
        applyStimulus(1'b1, 1'b0, 6);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 2);
        rst = 1'b0;
        checkOutput("rmid_player_y", 128'(player_y), 128'(240));
        checkOutput("rmid_ack_tgl",  128'(ack_tgl), 128'(0));
        checkOutput("rmid_obs_x3",   128'(obs_x_left[3*X_W +: X_W]), 128'(700));
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("rmid_no_snap",  128'(snap_upd), 128'(0));
        checkOutput("rmid_no_cap",   128'(player_y), 128'(240));
        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 10);

        // Five frames with requests on two of them.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 2);
        rst = 1'b0;
        for (int f = 0; f < 5; f++) begin
            if (f == 1 || f == 3) randomizeData();
            applyStimulus(1'b1, (f == 1 || f == 3) ? ~req_tgl : req_tgl, 12);
            applyStimulus(1'b0, req_tgl, 3);
        end
        applyStimulus(1'b1, req_tgl, 4);
`ifdef FRAME_SNAPSHOT_STATS_EN
        checkOutput("stats_frame_cnt", 128'(frame_cnt), 128'(5));
        checkOutput("stats_stale_cnt", 128'(stale_cnt), 128'(3));
`endif

        // Randomized frames and protocol-respecting requests.
        for (int f = 0; f < 40; f++) begin
            int hi;
            int lo;
            hi = $urandom_range(6, 30);
            lo = $urandom_range(1, 4);
            for (int c = 0; c < hi + lo; c++) begin
                logic reqNext;
                reqNext = req_tgl;
                if (req_tgl == expAck) begin
                    if ($urandom_range(0, 7) == 0) begin
                        randomizeData();
                        reqNext = ~req_tgl;
                    end else if ($urandom_range(0, 15) == 0) begin
                        randomizeData();
                    end
                end
                applyStimulus((c < hi) ? 1'b1 : 1'b0, reqNext, 1);
            end
        end
        applyStimulus(1'b1, req_tgl, 5);
`ifdef FRAME_SNAPSHOT_STATS_EN
        checkOutput("rand_frame_cnt", 128'(frame_cnt), 128'(expFrames[15:0]));
        checkOutput("rand_stale_cnt", 128'(stale_cnt), 128'(expStale[15:0]));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/frame_snapshot_rx.md
Name: frame_snapshot_rx

Overview:
- Receiving end of the game-to-display state handoff.
- The game domain stages obstacle, player and mode data, then flips a request toggle.
- This block synchronises the toggle into the pixel clock domain and captures the staged data into shadow registers only at the start of vertical sync, so a frame never mixes old and new state.
- It returns an ack toggle to the game side. It sits between game_logic/map and vga_screen_pic, in the 25 MHz pixel domain.

Parameters:
- N_OBS, 10, number of obstacle slots
- X_W, 10, obstacle x coordinate width
- Y_W, 9, obstacle/player y coordinate width
- SYNC_STAGES, 2, flops in the request-toggle synchroniser (legal range 2..4)

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst  in  1  synchronous reset, active-high
- req_tgl  in  1  request toggle from game domain (asynchronous)
- vs  in  1  VGA vertical sync from vga_ctrl, active-low pulse
- obs_x_left_in  in  N_OBS*X_W  staged obstacle left edges; held stable by writer until ack
- obs_x_right_in  in  N_OBS*X_W  staged obstacle right edges
- obs_y_up_in  in  N_OBS*Y_W  staged obstacle top edges
- obs_y_down_in  in  N_OBS*Y_W  staged obstacle bottom edges
- player_y_in  in  Y_W  staged player y
- gamemode_in  in  2  staged game mode
- ack_tgl  out  1  ack toggle back to game domain
- obs_x_left  out  N_OBS*X_W  shadow copy for renderer
- obs_x_right  out  N_OBS*X_W  shadow copy
- obs_y_up  out  N_OBS*Y_W  shadow copy
- obs_y_down  out  N_OBS*Y_W  shadow copy
- player_y  out  Y_W  shadow copy
- gamemode  out  2  shadow copy
- snap_upd  out  1  one-cycle pulse when the shadows changed

Behaviour:
- Reset values: all obs_x_* = 700, obs_y_* = 500, player_y = 240, gamemode = 0, ack_tgl = 0, snap_upd = 0, synchroniser flops = 0, vs_d = 1, state = IDLE.
- Synchroniser: req_s is req_tgl after SYNC_STAGES flops. req_pend = (req_s != ack_tgl).
- vs_edge = vs_d & ~vs, where vs_d is vs registered one cycle. It marks the start of the sync pulse.
- States:
  - IDLE: if req_pend and vs_edge, go to DONE and capture. If only req_pend, go to WAIT_VB. Otherwise stay.
  - WAIT_VB: on vs_edge, capture all *_in into the shadows and go to DONE. Otherwise stay. Shadows stay frozen while waiting.
  - DONE: ack_tgl <= ~ack_tgl and snap_upd = 1 for this cycle only. Always return to IDLE next cycle.
- Capture and the DONE transition share one clock edge. Shadows are therefore visible one cycle after the vs_edge cycle, and ack_tgl flips one cycle after that.
- Worst-case request-to-ack latency: SYNC_STAGES + one frame + 2 cycles.
- Protocol rule: the writer updates *_in, then flips req_tgl, and must not change *_in or flip again until it sees ack_tgl flip. The synchroniser delay guarantees the data is settled before capture. This block does not check for violations.
- A vs_edge with no request pending: shadows are untouched and no pulse is produced.
- A vs_edge while in DONE is ignored; a request pending at that point waits for the next frame.
- Reset mid-handshake: the block returns to reset defaults and any pending capture is discarded. The writer must also reset, since ack_tgl returns to 0.
- All arithmetic is unsigned. Only the optional counters wrap.

Optional Feature:
- Macro: FRAME_SNAPSHOT_STATS_EN.
- With the macro defined, two outputs are added:
  - frame_cnt [15:0]: increments on every vs_edge and wraps at 65535 -> 0.
  - stale_cnt [15:0]: increments on every vs_edge that sees no capture (state IDLE with no req_pend, or state WAIT_VB is impossible here because WAIT_VB always captures). It saturates at 65535.
  - Both reset to 0.
- Without the macro, neither port nor its counter logic exists, and behaviour is otherwise identical.

Decomposition:
- Shared package frame_snapshot_pkg holds:
  - N_OBS, X_W, Y_W defaults
  - reset constants OBS_X_RST = 700, OBS_Y_RST = 500, PLAYER_Y_RST = 240
  - state enum {IDLE, WAIT_VB, DONE}
- One sub-module, tgl_sync: a SYNC_STAGES-deep toggle synchroniser with reset to 0.

Test Plan:
- Reset: hold rst for 3 cycles -> obs_x_left[0] = 700, obs_y_up[9] = 500, player_y = 240, gamemode = 0, ack_tgl = 0, snap_upd = 0.
- Basic handshake: set player_y_in = 100 and gamemode_in = 1, flip req_tgl mid-frame -> shadows unchanged until the VS falling edge. player_y = 100 one cycle after the edge, snap_upd pulses once, ack_tgl = 1 one cycle later.
- Tear-freedom: change obs_x_left_in[3] from 200 to 300 without a request -> obs_x_left[3] stays at its old value across 3 frames.
- Simultaneous event: flip req_tgl so that req_s flips in the same cycle as vs_edge -> capture on that edge (IDLE->DONE directly), not on the next frame.
- Reset mid-handshake: flip req_tgl, assert rst in WAIT_VB before VS -> shadows at reset defaults, ack_tgl = 0, and no capture on the following VS edge.
- Stats (FRAME_SNAPSHOT_STATS_EN): run 5 VS pulses with 2 requests -> frame_cnt = 5, stale_cnt = 3.
